// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V pipeline front end: the canonical NOP
// and the fetch packet that travels from IF to ID.
package riscv_pkg;

  // Data width of the packet struct. The instruction queue's XLEN parameter
  // must match this value.
  localparam int RV_XLEN = 32;

  // addi x0, x0, 0 -- shown to decode whenever no real instruction is present
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0]        instr;
    logic [RV_XLEN-1:0] pc;
    logic [RV_XLEN-1:0] pcplus4;
    logic               pred_taken;
  } fetch_pkt_t;

  // Sequential PC. Wraps modulo 2^RV_XLEN, so 32'hFFFF_FFFC yields 0.
  function automatic logic [RV_XLEN-1:0] pc_plus4(input logic [RV_XLEN-1:0] pc);
    return pc + RV_XLEN'(4);
  endfunction

endpackage

// File: rtl/if_id_queue.sv
// IF -> ID instruction queue: a small circular FIFO of fetch packets with
// valid/ready handshakes on both sides. Flush empties it in one cycle, and an
// empty queue presents a NOP with zeroed PC fields to decode.
module if_id_queue
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2,   // power of two, 2..8
  parameter int XLEN  = 32   // must equal riscv_pkg::RV_XLEN
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     f_valid,
  output logic                     f_ready,
  input  logic [31:0]              f_instr,
  input  logic [XLEN-1:0]          f_pc,
  input  logic                     f_pred_taken,
  output logic                     d_valid,
  input  logic                     d_ready,
  output logic [31:0]              d_instr,
  output logic [XLEN-1:0]          d_pc,
  output logic [XLEN-1:0]          d_pcplus4,
  output logic                     d_pred_taken,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  fetch_pkt_t        mem_r [DEPTH];
  logic [PW-1:0]     wr_ptr_r;
  logic [PW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;

  logic              empty_s;
  logic              full_s;
  logic              push_s;
  logic              pop_s;
  fetch_pkt_t        wr_pkt_s;
  fetch_pkt_t        head_s;

  // Full/empty come from the occupancy register alone, never from the pointers.
  assign empty_s = (count_r == {CW{1'b0}});
  assign full_s  = (count_r == FULL_COUNT);

  // f_ready depends only on registered state and flush. A full queue refuses
  // a push even when decode pops in the same cycle.
  assign f_ready = !full_s && !flush;
  assign push_s  = f_valid && f_ready;
  assign pop_s   = !empty_s && d_ready && !flush;
  assign count   = count_r;

  // Build the packet to store. PC+4 is computed once here, at push time.
  always_comb begin
    wr_pkt_s            = '0;
    wr_pkt_s.instr      = f_instr;
    wr_pkt_s.pc         = f_pc;
    wr_pkt_s.pcplus4    = pc_plus4(f_pc);
    wr_pkt_s.pred_taken = f_pred_taken;
  end

  // Pointer and occupancy state. Flush wins over push and pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      // Pointers are PW bits wide and DEPTH is a power of two, so they wrap naturally.
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage. It has no reset, and a pop leaves the entry unchanged.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wr_pkt_s;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  assign head_s = mem_r[rd_ptr_r];

  // Present the head entry to decode, or a NOP with zero fields when the queue is empty.
  always_comb begin
    d_valid      = 1'b0;
    d_instr      = NOP_INSTR;
    d_pc         = {XLEN{1'b0}};
    d_pcplus4    = {XLEN{1'b0}};
    d_pred_taken = 1'b0;
    if (!empty_s) begin
      d_valid      = 1'b1;
      d_instr      = head_s.instr;
      d_pc         = head_s.pc;
      d_pcplus4    = head_s.pcplus4;
      d_pred_taken = head_s.pred_taken;
    end else begin
      d_valid      = 1'b0;
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed, table-driven bench for if_id_queue (DEPTH=2), with hand-written
// sequences for sustained streaming and asynchronous reset.
module tb_if_id_queue;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        f_valid;
  logic        f_ready;
  logic [31:0] f_instr;
  logic [31:0] f_pc;
  logic        f_pred_taken;
  logic        d_valid;
  logic        d_ready;
  logic [31:0] d_instr;
  logic [31:0] d_pc;
  logic [31:0] d_pcplus4;
  logic        d_pred_taken;
  logic [1:0]  count;

  int errors = 0;
  int checks = 0;

  if_id_queue #(.DEPTH(2), .XLEN(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .f_valid(f_valid), .f_ready(f_ready), .f_instr(f_instr),
    .f_pc(f_pc), .f_pred_taken(f_pred_taken),
    .d_valid(d_valid), .d_ready(d_ready), .d_instr(d_instr),
    .d_pc(d_pc), .d_pcplus4(d_pcplus4), .d_pred_taken(d_pred_taken),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        fl;
    logic        fv;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        pred;
    logic        dr;
    logic        edv;
    logic [31:0] einstr;
    logic [31:0] epc;
    logic [31:0] ep4;
    logic        epred;
    logic [1:0]  ecnt;
    logic        efr;
  } vec_t;

  vec_t vec [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic edv, input logic [31:0] ei,
                          input logic [31:0] ep, input logic [31:0] ep4, input logic epr,
                          input logic [1:0] ec, input logic efr);
    chk({tag, " d_valid"},      {31'd0, d_valid}, {31'd0, edv});
    chk({tag, " d_instr"},      d_instr, ei);
    chk({tag, " d_pc"},         d_pc, ep);
    chk({tag, " d_pcplus4"},    d_pcplus4, ep4);
    chk({tag, " d_pred_taken"}, {31'd0, d_pred_taken}, {31'd0, epr});
    chk({tag, " count"},        {30'd0, count}, {30'd0, ec});
    chk({tag, " f_ready"},      {31'd0, f_ready}, {31'd0, efr});
  endtask

  task automatic drive(input logic fl, input logic fv, input logic [31:0] ins,
                       input logic [31:0] pc, input logic pr, input logic dr);
    flush        = fl;
    f_valid      = fv;
    f_instr      = ins;
    f_pc         = pc;
    f_pred_taken = pr;
    d_ready      = dr;
  endtask

  initial begin
    // Inputs | expected outputs observed before the clock edge of that cycle.
    vec[0]  = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, NOP,          32'h0,        32'h0,   1'b0, 2'd0, 1'b1};
    vec[1]  = '{1'b0, 1'b1, 32'h00500093, 32'h100,      1'b1, 1'b0, 1'b0, NOP,          32'h0,        32'h0,   1'b0, 2'd0, 1'b1};
    vec[2]  = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 32'h00500093, 32'h100,      32'h104, 1'b1, 2'd1, 1'b1};
    vec[3]  = vec[2];
    vec[4]  = vec[2];
    vec[5]  = '{1'b0, 1'b1, 32'h00600113, 32'h104,      1'b0, 1'b0, 1'b1, 32'h00500093, 32'h100,      32'h104, 1'b1, 2'd1, 1'b1};
    vec[6]  = '{1'b0, 1'b1, 32'h00700193, 32'h108,      1'b0, 1'b0, 1'b1, 32'h00500093, 32'h100,      32'h104, 1'b1, 2'd2, 1'b0};
    vec[7]  = '{1'b0, 1'b1, 32'h00700193, 32'h108,      1'b0, 1'b1, 1'b1, 32'h00500093, 32'h100,      32'h104, 1'b1, 2'd2, 1'b0};
    vec[8]  = '{1'b0, 1'b1, 32'h00700193, 32'h108,      1'b0, 1'b1, 1'b1, 32'h00600113, 32'h104,      32'h108, 1'b0, 2'd1, 1'b1};
    vec[9]  = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 1'b1, 32'h00700193, 32'h108,      32'h10C, 1'b0, 2'd1, 1'b1};
    vec[10] = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, NOP,          32'h0,        32'h0,   1'b0, 2'd0, 1'b1};
    vec[11] = '{1'b0, 1'b1, 32'h11,       32'h10,       1'b0, 1'b0, 1'b0, NOP,          32'h0,        32'h0,   1'b0, 2'd0, 1'b1};
    vec[12] = '{1'b0, 1'b1, 32'h22,       32'h14,       1'b1, 1'b0, 1'b1, 32'h11,       32'h10,       32'h14,  1'b0, 2'd1, 1'b1};
    vec[13] = '{1'b1, 1'b1, 32'h33,       32'h200,      1'b1, 1'b1, 1'b1, 32'h11,       32'h10,       32'h14,  1'b0, 2'd2, 1'b0};
    vec[14] = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, NOP,          32'h0,        32'h0,   1'b0, 2'd0, 1'b1};
    vec[15] = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 1'b0, NOP,          32'h0,        32'h0,   1'b0, 2'd0, 1'b1};
    vec[16] = '{1'b0, 1'b1, 32'h44,       32'hFFFFFFFC, 1'b1, 1'b0, 1'b0, NOP,          32'h0,        32'h0,   1'b0, 2'd0, 1'b1};
    vec[17] = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 32'h44,       32'hFFFFFFFC, 32'h0,   1'b1, 2'd1, 1'b1};

    reset = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      drive(vec[i].fl, vec[i].fv, vec[i].instr, vec[i].pc, vec[i].pred, vec[i].dr);
      #1;
      chk_outs($sformatf("v%0d", i), vec[i].edv, vec[i].einstr, vec[i].epc, vec[i].ep4,
               vec[i].epred, vec[i].ecnt, vec[i].efr);
    end

    // Sustained push+pop: count holds at 1 while the PCs stream through in order.
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h300, 32'h300, 1'b0, 1'b1);
    #1;
    chk("stream0 d_pc", d_pc, 32'hFFFFFFFC);
    chk("stream0 count", {30'd0, count}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(1'b0, 1'b1, 32'h304 + 32'(i) * 32'd4, 32'h304 + 32'(i) * 32'd4, 1'b0, 1'b1);
      #1;
      chk($sformatf("stream%0d d_pc", i + 1), d_pc, 32'h300 + 32'(i) * 32'd4);
      chk($sformatf("stream%0d d_pcplus4", i + 1), d_pcplus4, 32'h304 + 32'(i) * 32'd4);
      chk($sformatf("stream%0d count", i + 1), {30'd0, count}, 32'd1);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    #1;
    chk("stream_end d_pc", d_pc, 32'h328);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("stream_drained d_valid", {31'd0, d_valid}, 32'd0);

    // Asynchronous reset in the middle of the low phase, with no clock edge involved.
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h55, 32'h500, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("pre_reset d_pc", d_pc, 32'h500);
    reset = 1'b1;
    #1;
    chk_outs("async_reset", 1'b0, NOP, 32'h0, 32'h0, 1'b0, 2'd0, 1'b1);
    reset = 1'b0;
    drive(1'b0, 1'b1, 32'h66, 32'h600, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    chk_outs("post_reset", 1'b1, 32'h66, 32'h600, 32'h604, 1'b0, 2'd1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
